music_player: RTL and testbench

//  Sequencer and tone driver downstream of the song ROMs (music_N). Steps rom_addr once per beat.

---
 rtl/music_pkg.sv | 55 +++++
 rtl/music_player_tone_gen.sv | 66 ++++++
 rtl/music_player.sv | 161 ++++++++++++++++
 tb/tb_music_player.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/music_pkg.sv
// -----------------------------------------------------------------------------
// music_pkg
// Shared definitions for the music player slice:
//   - note periods as full tone periods in clk cycles at 50 MHz
//   - REST_CODE, the period value that the player decodes as silence
//   - player_state_e, the sequencer state encoding
// -----------------------------------------------------------------------------
package music_pkg;

    // Period value that means "rest". A period of 0 is silent as well.
    localparam int REST_CODE = 2500;

    // Low octave (G4, A4, B4)
    localparam int D5  = 127551;
    localparam int D6  = 113636;
    localparam int D7  = 101239;

    // Middle octave (C5..B5)
    localparam int M1  = 95556;
    localparam int M2  = 85131;
    localparam int M3  = 75843;
    localparam int M4  = 71586;
    localparam int M5  = 63776;
    localparam int M6  = 56818;
    localparam int M7  = 50619;

    // Middle octave sharps
    localparam int M1S = 90193;
    localparam int M2S = 80354;
    localparam int M4S = 67568;
    localparam int M5S = 60197;
    localparam int M6S = 53629;

    // High octave (C6..B6)
    localparam int H1  = 47778;
    localparam int H2  = 42565;
    localparam int H3  = 37921;
    localparam int H4  = 35793;
    localparam int H5  = 31888;
    localparam int H6  = 28409;
    localparam int H7  = 25310;

    // Top notes (C7, D7)
    localparam int HH1 = 23889;
    localparam int HH2 = 21283;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH0 = 3'd1,
        ST_FETCH1 = 3'd2,
        ST_PLAY   = 3'd3,
        ST_DONE   = 3'd4
    } player_state_e;

endpackage

// File: rtl/music_player_tone_gen.sv
// -----------------------------------------------------------------------------
// tone_gen
// Square-wave generator for one note period.
//   clk     in   1       system clock
//   rst_n   in   1       asynchronous active-low reset
//   load    in   1       latch 'period' and restart the phase at count 0
//   period  in   NOTE_W  full tone period in clk cycles (0 / REST_CODE = silent)
//   enable  in   1       0 forces the output low; the counter keeps running
//   wave    out  1       registered square wave, high for the first period/2
//                        counts of each period
// -----------------------------------------------------------------------------
module tone_gen
    import music_pkg::*;
#(
    parameter int NOTE_W    = 17,
    parameter int REST_CODE = music_pkg::REST_CODE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [NOTE_W-1:0] period,
    input  logic              enable,
    output logic              wave
);

    localparam logic [NOTE_W-1:0] REST_VAL = NOTE_W'(REST_CODE);

    logic [NOTE_W-1:0] period_q, period_d;
    logic [NOTE_W-1:0] cnt_q, cnt_d;
    logic              wave_q, wave_d;
    logic              cur_silent, next_silent;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_q <= '0;
            cnt_q    <= '0;
            wave_q   <= 1'b0;
        end else begin
            period_q <= period_d;
            cnt_q    <= cnt_d;
            wave_q   <= wave_d;
        end
    end

    always_comb begin
        cur_silent = (period_q == '0) || (period_q == REST_VAL);
        period_d   = period_q;
        cnt_d      = cnt_q;
        if (load) begin
            period_d = period;
            cnt_d    = '0;
        end else if (cur_silent || (cnt_q == period_q - NOTE_W'(1))) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + NOTE_W'(1);
        end
        // The wave is computed from the next counter value so that the
        // registered output lines up with cnt_q (high on count 0 right after
        // a load). Odd periods leave the low phase one cycle longer.
        next_silent = (period_d == '0) || (period_d == REST_VAL);
        wave_d      = enable && !next_silent && (cnt_d < (period_d >> 1));
    end

    assign wave = wave_q;

endmodule

// File: rtl/music_player.sv
// -----------------------------------------------------------------------------
// music_player
// Steps a song ROM once per beat, latches each returned note period into the
// tone generator and drives a square wave on the buzzer pin.
//   clk        in   1       system clock
//   rst_n      in   1       asynchronous active-low reset
//   start      in   1       pulse: begin song at address 0 (ignored while busy)
//   stop       in   1       pulse: abort playback (wins over start)
//   loop_en    in   1       wrap to address 0 after the last entry
//   rom_addr   out  ADDR_W  song ROM address
//   rom_note   in   NOTE_W  ROM data, valid one cycle after rom_addr
//   buzzer     out  1       registered square-wave tone
//   busy       out  1       high in FETCH0 / FETCH1 / PLAY
//   beat_tick  out  1       pulse in the cycle after a note is latched
//   done       out  1       pulse at song end (non-loop)
// Build option: define MUSIC_PLAYER_ARTIC_EN to silence the buzzer for the
// last GAP_CYCLES PLAY cycles of every beat, so repeated notes are separated.
// -----------------------------------------------------------------------------
module music_player
    import music_pkg::*;
#(
    parameter int ADDR_W      = 7,
    parameter int NOTE_W      = 17,
    parameter int SONG_LEN    = 128,
    parameter int BEAT_CYCLES = 12_500_000,
    parameter int REST_CODE   = music_pkg::REST_CODE,
    parameter int GAP_CYCLES  = 1_250_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [NOTE_W-1:0] rom_note,
    output logic              buzzer,
    output logic              busy,
    output logic              beat_tick,
    output logic              done
);

    localparam int                BEAT_W    = $clog2(BEAT_CYCLES);
    // FETCH0 + FETCH1 + (BEAT_CYCLES-2) PLAY cycles counting down to 0.
    localparam logic [BEAT_W-1:0] BEAT_LOAD = BEAT_W'(BEAT_CYCLES - 3);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SONG_LEN - 1);

    if ((SONG_LEN < 1) || (SONG_LEN > (1 << ADDR_W))) begin : g_bad_song_len
        $error("music_player: SONG_LEN must be in 1..2**ADDR_W");
    end
    if ((BEAT_CYCLES < 4) || (GAP_CYCLES >= BEAT_CYCLES - 2)) begin : g_bad_beat
        $error("music_player: need BEAT_CYCLES >= 4 and GAP_CYCLES < BEAT_CYCLES-2");
    end

    player_state_e     state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              beat_tick_q, beat_tick_d;
    logic              stop_hit;
    logic              tone_load;
    logic [NOTE_W-1:0] tone_period;
    logic              tone_enable;

    assign stop_hit = stop && (state_q != ST_IDLE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            beat_q      <= '0;
            beat_tick_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            beat_q      <= beat_d;
            beat_tick_q <= beat_tick_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        beat_d  = beat_q;
        if (stop_hit) begin
            state_d = ST_IDLE;
            addr_d  = '0;
            beat_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && !stop) begin
                        state_d = ST_FETCH0;
                        addr_d  = '0;
                    end
                end
                ST_FETCH0: state_d = ST_FETCH1;
                ST_FETCH1: begin
                    state_d = ST_PLAY;
                    beat_d  = BEAT_LOAD;
                end
                ST_PLAY: begin
                    if (beat_q == '0) begin
                        if (addr_q == LAST_ADDR) begin
                            // loop_en only matters at this decision point
                            if (loop_en) begin
                                addr_d  = '0;
                                state_d = ST_FETCH0;
                            end else begin
                                state_d = ST_DONE;
                            end
                        end else begin
                            addr_d  = addr_q + ADDR_W'(1);
                            state_d = ST_FETCH0;
                        end
                    end else begin
                        beat_d = beat_q - BEAT_W'(1);
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                    addr_d  = '0;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Output logic
    always_comb begin
        busy        = (state_q == ST_FETCH0) || (state_q == ST_FETCH1) || (state_q == ST_PLAY);
        done        = (state_q == ST_DONE);
        beat_tick_d = (state_q == ST_FETCH1) && !stop_hit;
        // A load of period 0 clears the tone generator on stop and at song end;
        // during FETCH0/FETCH1 the previous note keeps running untouched.
        tone_load   = stop_hit || (state_q == ST_FETCH1) || (state_q == ST_DONE);
        tone_period = ((state_q == ST_FETCH1) && !stop_hit) ? rom_note : '0;
`ifdef MUSIC_PLAYER_ARTIC_EN
        // Look at next-cycle state/counter because the buzzer is registered.
        tone_enable = !((state_d == ST_PLAY) && (beat_d < BEAT_W'(GAP_CYCLES)));
`else
        tone_enable = 1'b1;
`endif
    end

    tone_gen #(
        .NOTE_W    (NOTE_W),
        .REST_CODE (REST_CODE)
    ) u_tone (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (tone_load),
        .period (tone_period),
        .enable (tone_enable),
        .wave   (buzzer)
    );

    assign rom_addr  = addr_q;
    assign beat_tick = beat_tick_q;

endmodule

// File: tb/tb_music_player.sv
`timescale 1ns/1ps
module tb_music_player;

    localparam int ADDR_W   = 7;
    localparam int NOTE_W   = 17;
    localparam int SONG_LEN = 4;
    localparam int BEAT     = 16;
    localparam int GAP      = 4;
    localparam int REST     = 2500;
    localparam int SONG_CYC = SONG_LEN * BEAT;
`ifdef MUSIC_PLAYER_ARTIC_EN
    localparam bit ARTIC = 1'b1;
`else
    localparam bit ARTIC = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic              loop_en = 1'b0;
    logic [ADDR_W-1:0] rom_addr;
    logic [NOTE_W-1:0] rom_note;
    logic              buzzer, busy, beat_tick, done;

    logic [NOTE_W-1:0] rom_mem [0:(1<<ADDR_W)-1];

    always #5 clk = ~clk;

    // Behavioural registered ROM
    always @(posedge clk) rom_note <= rom_mem[rom_addr];

    music_player #(
        .ADDR_W(ADDR_W), .NOTE_W(NOTE_W), .SONG_LEN(SONG_LEN),
        .BEAT_CYCLES(BEAT), .REST_CODE(REST), .GAP_CYCLES(GAP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop_en(loop_en),
        .rom_addr(rom_addr), .rom_note(rom_note), .buzzer(buzzer),
        .busy(busy), .beat_tick(beat_tick), .done(done)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // A session is described by its time t in cycles since FETCH0 entry.
    // mode 0 = idle, 1 = playing, 2 = the single done cycle.
    int m_mode = 0;
    int m_t = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode <= 0;
            m_t    <= 0;
        end else begin
            case (m_mode)
                0: if (start && !stop) begin m_mode <= 1; m_t <= 0; end
                1: begin
                    if (stop) m_mode <= 0;
                    else begin
                        m_t <= m_t + 1;
                        if ((m_t % SONG_CYC == SONG_CYC - 1) && !loop_en) m_mode <= 2;
                    end
                end
                default: m_mode <= 0;
            endcase
        end
    end

    // Note n is latched so it sounds from t = n*BEAT+2; during the two fetch
    // cycles of a beat the previous note keeps going.
    function automatic int exp_buzz(input int t, input bit playing);
        int b, p, n, k, per;
        b = t / BEAT;
        p = t % BEAT;
        n = (p >= 2) ? b : b - 1;
        if (n < 0) return 0;
        per = int'(rom_mem[n % SONG_LEN]);
        if (per == 0 || per == REST) return 0;
        if (ARTIC && playing && p >= 2 && (BEAT - 1 - p) < GAP) return 0;
        k = t - (n * BEAT + 2);
        return ((k % per) < (per / 2)) ? 1 : 0;
    endfunction

    always @(negedge clk) begin : cmp
        int e_addr, e_busy, e_tick, e_done, e_buzz;
        e_addr = 0; e_busy = 0; e_tick = 0; e_done = 0; e_buzz = 0;
        if (m_mode == 1) begin
            e_addr = (m_t / BEAT) % SONG_LEN;
            e_busy = 1;
            e_tick = (m_t % BEAT == 2) ? 1 : 0;
            e_buzz = exp_buzz(m_t, 1'b1);
        end else if (m_mode == 2) begin
            e_addr = SONG_LEN - 1;
            e_done = 1;
            e_buzz = exp_buzz(m_t, 1'b0);
        end
        check("rom_addr", 32'(rom_addr), e_addr);
        check("busy", 32'(busy), e_busy);
        check("beat_tick", 32'(beat_tick), e_tick);
        check("done", 32'(done), e_done);
        check("buzzer", 32'(buzzer), e_buzz);
    end

    // ---------------- event monitor ----------------
    int done_cnt = 0, done_cyc = 0, tick_cnt = 0, buzz_cnt = 0;
    int tick_addr[$];

    always @(negedge clk) begin
        if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
        if (beat_tick === 1'b1) begin tick_cnt++; tick_addr.push_back(int'(rom_addr)); end
        if (buzzer === 1'b1) buzz_cnt++;
    end

    task automatic clear_counts();
        done_cnt = 0; done_cyc = 0; tick_cnt = 0; buzz_cnt = 0;
        tick_addr.delete();
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic set_rom(input int a, input int b, input int c, input int d);
        rom_mem[0] = NOTE_W'(a); rom_mem[1] = NOTE_W'(b);
        rom_mem[2] = NOTE_W'(c); rom_mem[3] = NOTE_W'(d);
    endtask

    function automatic logic [NOTE_W-1:0] rand_note();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return '0;
        if (r == 1) return NOTE_W'(REST);
        return NOTE_W'($urandom_range(1, 24));
    endfunction

    int f0;
    int exp_seq[6] = '{0, 1, 2, 3, 0, 1};

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) rom_mem[i] = '0;
        set_rom(10, 10, 2500, 6);

        // Reset state
        repeat (3) tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_rom_addr", 32'(rom_addr), 0);
        check("rst_buzzer", 32'(buzzer), 0);
        check("rst_done", 32'(done), 0);
        rst_n = 1'b1;
        tick();

        // 1: asynchronous reset in the middle of beat 1 (addr 1, buzzer high)
        pulse_start();
        repeat (20) tick();
        rst_n = 1'b0;
        #1;
        check("async_busy", 32'(busy), 0);
        check("async_rom_addr", 32'(rom_addr), 0);
        check("async_buzzer", 32'(buzzer), 0);
        check("async_beat_tick", 32'(beat_tick), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_addr", 32'(rom_addr), 0);
        check("post_rst_busy", 32'(busy), 0);

        // 2: single play through, no loop
        loop_en = 1'b0;
        clear_counts();
        pulse_start();
        f0 = cyc;
        repeat (70) tick();
        check("t2_done_cnt", 32'(done_cnt), 1);
        check("t2_done_delay", 32'(done_cyc - f0), 64);
        check("t2_tick_cnt", 32'(tick_cnt), 4);
        for (int i = 0; i < 4; i++)
            check("t2_addr_seq", 32'((i < tick_addr.size()) ? tick_addr[i] : -1), exp_seq[i]);
        check("t2_buzz_high_cycles", 32'(buzz_cnt), ARTIC ? 19 : 29);

        // 3: looping
        loop_en = 1'b1;
        clear_counts();
        pulse_start();
        repeat (85) tick();
        check("t3_tick_cnt", 32'(tick_cnt), 6);
        for (int i = 0; i < 6; i++)
            check("t3_addr_seq", 32'((i < tick_addr.size()) ? tick_addr[i] : -1), exp_seq[i]);
        check("t3_no_done", 32'(done_cnt), 0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("t3_stop_busy", 32'(busy), 0);

        // 4: stop 5 cycles into beat 1, then start+stop together from idle
        loop_en = 1'b0;
        clear_counts();
        pulse_start();
        repeat (21) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("t4_stop_busy", 32'(busy), 0);
        check("t4_stop_buzzer", 32'(buzzer), 0);
        check("t4_stop_rom_addr", 32'(rom_addr), 0);
        repeat (70) tick();
        check("t4_no_done", 32'(done_cnt), 0);
        start = 1'b1;
        stop = 1'b1;
        tick();
        start = 1'b0;
        stop = 1'b0;
        check("t4_start_stop_busy", 32'(busy), 0);
        repeat (5) tick();
        check("t4_tick_cnt", 32'(tick_cnt), 2);

        // 5: start during PLAY is ignored
        clear_counts();
        pulse_start();
        f0 = cyc;
        repeat (20) tick();
        pulse_start();
        repeat (50) tick();
        check("t5_done_cnt", 32'(done_cnt), 1);
        check("t5_done_delay", 32'(done_cyc - f0), 64);
        check("t5_tick_cnt", 32'(tick_cnt), 4);

        // 6: identical notes
        set_rom(10, 10, 10, 10);
        clear_counts();
        pulse_start();
        repeat (70) tick();
        check("t6_done_cnt", 32'(done_cnt), 1);

        // Randomized traffic; ROM only changes while the player is idle
        for (int i = 0; i < SONG_LEN; i++) rom_mem[i] = rand_note();
        for (int c = 0; c < 3000; c++) begin
            start = ($urandom_range(0, 24) == 0);
            stop  = ($urandom_range(0, 249) == 0);
            if ($urandom_range(0, 63) == 0) loop_en = ~loop_en;
            if (m_mode == 0 && !start && $urandom_range(0, 7) == 0)
                rom_mem[$urandom_range(0, SONG_LEN - 1)] = rand_note();
            tick();
        end
        start = 1'b0;
        stop = 1'b0;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
